pixel_sequencer: RTL and testbench
==================================

# pixel_sequencer

Frame-level controller for the image-sensor pixel array. It runs the pixel array through erase, exposure, ramp-ADC conversion and row-by-row readout. During readout it owns the row-select lines, so exactly one row drives the shared tristated 16-bit pixel data bus at a time. It sits inside the sensor top level, next to the pixel array, and is the only source of the array's phase-control signals.

## Interface

Parameters:
- ERASE_CYCLES, 5: cycles `erase` is held high (≥1)
- EXPOSE_CYCLES, 255: cycles `expose` is held high (≥1)
- ADC_BITS, 8: ramp/ADC code width; conversion lasts 2^ADC_BITS cycles
- GRAY_CODE, 1: 1 = `adcCode` is Gray-coded, 0 = plain binary
- NUM_ROWS, 2: rows sharing the pixel data bus (≥1)
- READ_CYCLES, 2: cycles each row stays selected (≥1)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a frame; level-sampled only in IDLE and DONE
- erase  out  1  pixel reset phase
- expose  out  1  integration phase
- convert  out  1  ADC ramp phase; pixels latch `adcCode` on comparator trip
- adcCode  out  ADC_BITS  ramp code broadcast to all pixels
- readEn  out  1  readout phase active
- rowSel  out  NUM_ROWS  one-hot row bus-drive enable
- frameDone  out  1  one-cycle pulse at end of frame

## Operation

- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE. All outputs are registered and decoded from state.
- Reset is synchronous and takes priority over everything. It forces IDLE and clears all outputs: erase=expose=convert=readEn=frameDone=0, rowSel=0, adcCode=0, and all counters to 0. A reset mid-frame aborts the frame with no frameDone.
- IDLE: start=1 → ERASE. Otherwise stay.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles → EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles → CONVERT.
- CONVERT: convert=1 for exactly 2^ADC_BITS cycles.
  - A binary counter b runs 0 … 2^ADC_BITS−1, one step per cycle.
  - adcCode = b ^ (b>>1) when GRAY_CODE=1, else b.
  - Terminal count → READ; b does not wrap within the phase.
- READ: readEn=1. Row index r runs 0 … NUM_ROWS−1.
  - rowSel = (1<<r), held for READ_CYCLES cycles per row.
  - After the last row's final cycle → DONE.
- DONE: frameDone=1 for one cycle.
  - start=1 → ERASE: back-to-back frame with no IDLE cycle.
  - Otherwise → IDLE.
- Invariants:
  - At most one of erase/expose/convert/readEn is high in any cycle.
  - rowSel is non-zero only while readEn=1 and is never multi-hot, so the bus is never double-driven.
  - adcCode is 0 outside CONVERT.
- start is ignored in ERASE, EXPOSE, CONVERT and READ. Pulses there are not queued.
- Counter widths: the phase counter is sized to clog2 of max(ERASE_CYCLES, EXPOSE_CYCLES, 2^ADC_BITS, READ_CYCLES). The row counter is clog2(NUM_ROWS), minimum 1 bit. No overflow is possible within legal parameters.

## Timing

- Latency: start sampled high at edge t (in IDLE) → erase high in the cycle after t.
- Frame length from the first erase cycle to frameDone, inclusive: ERASE_CYCLES + EXPOSE_CYCLES + 2^ADC_BITS + NUM_ROWS·READ_CYCLES + 1 cycles. With defaults this is 5+255+256+4+1 = 521.
- Phase transitions have no gap cycles. The last cycle of one phase is immediately followed by the first cycle of the next.
- adcCode changes every cycle during CONVERT. Under GRAY_CODE=1, consecutive codes differ in exactly one bit.
- Row handover is a clean cut: rowSel bit r falls on the same edge that bit r+1 rises.
- With start held high continuously, frame period = 521 cycles (defaults).

## Test plan

- Reset/idle: assert reset for 2 cycles with start=0 → all outputs 0 and stay 0 for 20 cycles. Assert reset mid-CONVERT (e.g., adcCode = gray(100)) → next cycle all outputs 0, state IDLE, no frameDone.
- Single frame, defaults: one-cycle start pulse in IDLE → erase cycles 1–5, expose 6–260, convert 261–516, rowSel=01 in 517–518, rowSel=10 in 519–520, frameDone only in cycle 521, IDLE at 522.
- ADC ramp: check adcCode in CONVERT:
  - GRAY_CODE=1: codes 0,1,3,2,6,… with single-bit change every cycle; last code 0x80.
  - GRAY_CODE=0: codes 0…255 in order.
- Back-to-back: hold start=1 → erase rises in the cycle immediately after each frameDone; 3 frames complete in 1563 cycles.
- Ignored start: pulse start during EXPOSE and READ → frame timing unchanged, no second frame after DONE.
- Parameter sweep (ERASE_CYCLES=1, EXPOSE_CYCLES=1, ADC_BITS=2, NUM_ROWS=4, READ_CYCLES=1): frame = 1+1+4+4+1 = 11 cycles. rowSel steps 0001→0010→0100→1000; mutual-exclusion and one-hot assertions hold throughout.

Source files
------------

// File: rtl/pixel_sequencer_if.sv
// Phase-control and row-select bundle between the frame sequencer and the pixel array.
interface pixel_sequencer_if #(
  parameter int unsigned ADC_BITS = 8,
  parameter int unsigned NUM_ROWS = 2
);
  logic                start;
  logic                erase;
  logic                expose;
  logic                convert;
  logic [ADC_BITS-1:0] adcCode;
  logic                readEn;
  logic [NUM_ROWS-1:0] rowSel;
  logic                frameDone;

  modport master (
    input  start,
    output erase, expose, convert, adcCode, readEn, rowSel, frameDone
  );

  modport slave (
    output start,
    input  erase, expose, convert, adcCode, readEn, rowSel, frameDone
  );
endinterface

// File: rtl/pixel_sequencer.sv
// Frame controller: erase, expose, ramp-ADC convert, then one-hot row readout.
module pixel_sequencer #(
  parameter int unsigned ERASE_CYCLES  = 5,
  parameter int unsigned EXPOSE_CYCLES = 255,
  parameter int unsigned ADC_BITS      = 8,
  parameter bit          GRAY_CODE     = 1'b1,
  parameter int unsigned NUM_ROWS      = 2,
  parameter int unsigned READ_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  pixel_sequencer_if.master   bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CONV_CYCLES = 32'd1 << ADC_BITS;
  localparam int unsigned MAX_CYC     = max2(max2(ERASE_CYCLES, EXPOSE_CYCLES),
                                             max2(CONV_CYCLES, READ_CYCLES));
  localparam int unsigned CNT_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [ADC_BITS-1:0] bin_code;

  logic                erase_nxt, expose_nxt, convert_nxt, read_en_nxt, frame_done_nxt;
  logic [ADC_BITS-1:0] adc_code_nxt;
  logic [NUM_ROWS-1:0] row_sel_nxt;

  // Next state and counters; the phase counter restarts at 0 on every phase entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_ERASE;
          cnt_nxt   = '0;
        end
      end
      S_ERASE: begin
        if (cnt == CNT_W'(ERASE_CYCLES - 1)) begin
          state_nxt = S_EXPOSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_EXPOSE: begin
        if (cnt == CNT_W'(EXPOSE_CYCLES - 1)) begin
          state_nxt = S_CONVERT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
          state_nxt = S_READ;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_READ: begin
        if (cnt == CNT_W'(READ_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (row == ROW_W'(NUM_ROWS - 1)) begin
            state_nxt = S_DONE;
            row_nxt   = '0;
          end else begin
            row_nxt = row + ROW_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_nxt   = '0;
        row_nxt   = '0;
        state_nxt = bus.start ? S_ERASE : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        row_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so each register lines up with its phase.
  always_comb begin
    erase_nxt      = (state_nxt == S_ERASE);
    expose_nxt     = (state_nxt == S_EXPOSE);
    convert_nxt    = (state_nxt == S_CONVERT);
    read_en_nxt    = (state_nxt == S_READ);
    frame_done_nxt = (state_nxt == S_DONE);
    bin_code       = ADC_BITS'(cnt_nxt);
    adc_code_nxt   = '0;
    row_sel_nxt    = '0;
    if (state_nxt == S_CONVERT) begin
      adc_code_nxt = GRAY_CODE ? (bin_code ^ (bin_code >> 1)) : bin_code;
    end
    if (state_nxt == S_READ) begin
      row_sel_nxt = NUM_ROWS'(1) << row_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      row           <= '0;
      bus.erase     <= 1'b0;
      bus.expose    <= 1'b0;
      bus.convert   <= 1'b0;
      bus.adcCode   <= '0;
      bus.readEn    <= 1'b0;
      bus.rowSel    <= '0;
      bus.frameDone <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      row           <= row_nxt;
      bus.erase     <= erase_nxt;
      bus.expose    <= expose_nxt;
      bus.convert   <= convert_nxt;
      bus.adcCode   <= adc_code_nxt;
      bus.readEn    <= read_en_nxt;
      bus.rowSel    <= row_sel_nxt;
      bus.frameDone <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Scoreboard bench: a default-parameter sequencer and a small swept-parameter one run side by side.
module tb_pixel_sequencer;

  logic clk = 1'b0;
  logic rst0, rst1;
  bit   armed0 = 1'b0, armed1 = 1'b0, done1 = 1'b0;
  int   n_checks = 0, n_fail = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] obs0, exp0, obs1, exp1;
  logic [7:0]  prev_adc0;
  logic        prev_conv0 = 1'b0;

  always #5 clk = ~clk;

  pixel_sequencer_if #(.ADC_BITS(8), .NUM_ROWS(2)) bus0 ();
  pixel_sequencer_if #(.ADC_BITS(2), .NUM_ROWS(4)) bus1 ();

  pixel_sequencer dut0 (.clk(clk), .reset(rst0), .bus(bus0));

  pixel_sequencer #(
    .ERASE_CYCLES(1), .EXPOSE_CYCLES(1), .ADC_BITS(2), .GRAY_CODE(1'b0),
    .NUM_ROWS(4), .READ_CYCLES(1)
  ) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected output word for frame cycle k (1-based), built from the phase timing.
  // Layout: [16]erase [15]expose [14]convert [13]readEn [12]frameDone [11:8]rowSel [7:0]adcCode
  function automatic logic [31:0] frame_vec(input int k, input int e, input int x,
                                            input int ab, input int g, input int n, input int r);
    int c;
    int b;
    int j;
    logic [7:0]  code;
    logic [31:0] v;
    c = 1 << ab;
    v = '0;
    if (k <= e) v[16] = 1'b1;
    else if (k <= e + x) v[15] = 1'b1;
    else if (k <= e + x + c) begin
      b = k - e - x - 1;
      code = 8'(b);
      if (g != 0) code = code ^ (code >> 1);
      v[14] = 1'b1;
      v[7:0] = code;
    end else if (k <= e + x + c + n * r) begin
      j = k - e - x - c - 1;
      v[13] = 1'b1;
      v[11:8] = 4'(1 << (j / r));
    end else v[12] = 1'b1;
    return v;
  endfunction

  task automatic push_frames(input int id, input int nf);
    int len;
    if (id == 0) begin
      len = 5 + 255 + 256 + 2 * 2 + 1;
      for (int f = 0; f < nf; f++)
        for (int k = 1; k <= len; k++) q0.push_back(frame_vec(k, 5, 255, 8, 1, 2, 2));
    end else begin
      len = 1 + 1 + 4 + 4 * 1 + 1;
      for (int f = 0; f < nf; f++)
        for (int k = 1; k <= len; k++) q1.push_back(frame_vec(k, 1, 1, 2, 0, 4, 1));
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitors: every armed cycle pops the expected word, or expects all-zero when nothing is pending.
  always @(negedge clk) begin
    if (armed0) begin
      obs0 = {15'd0, bus0.erase, bus0.expose, bus0.convert, bus0.readEn, bus0.frameDone,
              2'b00, bus0.rowSel, bus0.adcCode};
      exp0 = (q0.size() > 0) ? q0.pop_front() : 32'd0;
      check_eq("seq_dflt", obs0, exp0);
      if (bus0.convert && prev_conv0)
        check_eq("gray_step", 32'($countones(bus0.adcCode ^ prev_adc0)), 32'd1);
      prev_conv0 = bus0.convert;
      prev_adc0  = bus0.adcCode;
    end
    if (armed1) begin
      obs1 = {15'd0, bus1.erase, bus1.expose, bus1.convert, bus1.readEn, bus1.frameDone,
              bus1.rowSel, 6'd0, bus1.adcCode};
      exp1 = (q1.size() > 0) ? q1.pop_front() : 32'd0;
      check_eq("seq_small", obs1, exp1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Small-parameter instance: single frame with an ignored READ pulse, then back-to-back frames.
  initial begin
    rst1 = 1'b1;
    bus1.start = 1'b0;
    @(negedge clk); #1 armed1 = 1'b1;
    wait_cyc(1);
    rst1 = 1'b0;
    wait_cyc(5);
    bus1.start = 1'b1; push_frames(1, 1);
    wait_cyc(1); bus1.start = 1'b0;
    wait_cyc(7); bus1.start = 1'b1;
    wait_cyc(1); bus1.start = 1'b0;
    wait_cyc(12);
    bus1.start = 1'b1; push_frames(1, 3);
    wait_cyc(25); bus1.start = 1'b0;
    wait_cyc(18);
    check_eq("drain_small", 32'(q1.size()), 32'd0);
    done1 = 1'b1;
  end

  // Default instance: reset/idle, single frame with ignored pulses, back-to-back, mid-convert reset.
  initial begin
    rst0 = 1'b1;
    bus0.start = 1'b0;
    @(negedge clk); #1 armed0 = 1'b1;
    wait_cyc(1);
    rst0 = 1'b0;
    wait_cyc(20);

    bus0.start = 1'b1; push_frames(0, 1);
    wait_cyc(1); bus0.start = 1'b0;
    wait_cyc(99); bus0.start = 1'b1;
    wait_cyc(1); bus0.start = 1'b0;
    wait_cyc(416); bus0.start = 1'b1;
    wait_cyc(1); bus0.start = 1'b0;
    wait_cyc(14);
    check_eq("drain_single", 32'(q0.size()), 32'd0);

    bus0.start = 1'b1; push_frames(0, 3);
    wait_cyc(1242); bus0.start = 1'b0;
    wait_cyc(331);
    check_eq("drain_b2b", 32'(q0.size()), 32'd0);

    bus0.start = 1'b1; push_frames(0, 1);
    wait_cyc(1); bus0.start = 1'b0;
    wait_cyc(360);
    check_eq("adc_mid", 32'(bus0.adcCode), 32'(8'd100 ^ 8'd50));
    rst0 = 1'b1; q0.delete();
    wait_cyc(2);
    rst0 = 1'b0;
    wait_cyc(20);

    wait (done1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
